// File: rtl/mem_lsu_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
interface mem_lsu_if #(
    parameter int XLEN = 64
);
    localparam int STRB = XLEN / 8;

    logic            req_valid;
    logic            req_ready;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [STRB-1:0] wmask;
    logic            resp_valid;
    logic [XLEN-1:0] rdata;
    logic            err;

    modport master (
        output req_valid, we, addr, wdata, wmask,
        input  req_ready, resp_valid, rdata, err
    );

    modport slave (
        input  req_valid, we, addr, wdata, wmask,
        output req_ready, resp_valid, rdata, err
    );
endinterface

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: lane steering, load extension and a valid/ready bus FSM.
// Build option LSU_MISALIGN_TRAP_EN: fault misaligned accesses instead of forcing alignment.
module mem_lsu #(
    parameter int XLEN    = 64,
    parameter int RD_BITS = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_in,
    input  logic               flush_in,
    input  logic               valid_in,
    input  logic               read_in,
    input  logic               write_in,
    input  logic [2:0]         width_in,
    input  logic [RD_BITS-1:0] rd_in,
    input  logic               rd_write_in,
    input  logic [XLEN-1:0]    result_in,
    input  logic [XLEN-1:0]    rs2_value_in,
    output logic               busy_out,
    mem_lsu_if.master          bus,
    output logic               valid_out,
    output logic [RD_BITS-1:0] rd_out,
    output logic               rd_write_out,
    output logic [XLEN-1:0]    rd_value_out,
    output logic               fault_out,
    output logic [1:0]         fault_cause_out
);
    localparam int STRB = XLEN / 8;
    localparam int OFFW = $clog2(STRB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0]    addr_q, wdata_q, result_q, hold_rdata_q;
    logic [STRB-1:0]    mask_q;
    logic               we_q, rdw_q, zext_q, hold_q, hold_err_q;
    logic [RD_BITS-1:0] rd_q;
    logic [1:0]         size_q;
    logic [OFFW-1:0]    off_q;

    logic [1:0]         size_in;
    logic [OFFW-1:0]    size_lo, off_in;
    logic [STRB-1:0]    mask_in;
    logic [XLEN-1:0]    wdata_in;
    logic               misalign, mem_op;

    logic [XLEN-1:0]    src_rdata, shifted, ld_value;
    logic               src_err, resp_here;

    logic               accept, out_en, cap_hold, clr_hold;
    logic               o_valid, o_rdw, o_fault;
    logic [RD_BITS-1:0] o_rd;
    logic [XLEN-1:0]    o_value;
    logic [1:0]         o_cause;

    // A doubleword on a 32-bit bus degrades to a word access.
    always_comb begin
        size_in = width_in[1:0];
        if (XLEN == 32 && size_in == 2'd3) size_in = 2'd2;
    end

    assign size_lo = OFFW'((1 << size_in) - 1);
    assign mem_op  = valid_in & (read_in | write_in);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = |(result_in[OFFW-1:0] & size_lo);
    assign off_in   = result_in[OFFW-1:0];
`else
    assign misalign = 1'b0;
    assign off_in   = result_in[OFFW-1:0] & ~size_lo;
`endif

    assign mask_in = STRB'(((1 << (1 << size_in)) - 1) << off_in);

    // Lane i carries byte (i mod access-size) of the store data.
    always_comb begin
        wdata_in = '0;
        for (int i = 0; i < STRB; i++)
            wdata_in[8*i +: 8] = rs2_value_in[8*(i & int'(size_lo)) +: 8];
    end

    assign resp_here = hold_q | bus.resp_valid;
    assign src_rdata = hold_q ? hold_rdata_q : bus.rdata;
    assign src_err   = hold_q ? hold_err_q : bus.err;
    assign shifted   = src_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    ld_value = zext_q ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            2'd1:    ld_value = zext_q ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            2'd2:    ld_value = zext_q ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: ld_value = shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        out_en   = 1'b0;
        cap_hold = 1'b0;
        clr_hold = 1'b0;
        o_valid  = 1'b0;
        o_rd     = rd_q;
        o_rdw    = 1'b0;
        o_value  = '0;
        o_fault  = 1'b0;
        o_cause  = 2'd0;
        case (state_q)
            IDLE: if (!stall_in) begin
                out_en  = 1'b1;
                o_rd    = rd_in;
                o_value = result_in;
                if (flush_in) begin
                    o_valid = 1'b0;
                end else if (mem_op && misalign) begin
                    o_valid = 1'b1;
                    o_fault = 1'b1;
                    o_cause = 2'd1;
                end else if (mem_op) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end else begin
                    o_valid = valid_in;
                    o_rdw   = valid_in & rd_write_in;
                end
            end
            REQ: begin
                if (flush_in)            state_d = bus.req_ready ? DRAIN : IDLE;
                else if (bus.req_ready)  state_d = WAIT;
            end
            WAIT: begin
                // A response already in hand needs no drain after a flush.
                if (flush_in) begin
                    clr_hold = 1'b1;
                    state_d  = resp_here ? IDLE : DRAIN;
                end else if (resp_here) begin
                    if (stall_in) begin
                        cap_hold = !hold_q;
                    end else begin
                        out_en   = 1'b1;
                        clr_hold = 1'b1;
                        o_valid  = 1'b1;
                        o_rdw    = rdw_q & !src_err;
                        o_value  = src_err ? '0 : (we_q ? result_q : ld_value);
                        o_fault  = src_err;
                        o_cause  = src_err ? 2'd2 : 2'd0;
                        state_d  = IDLE;
                    end
                end
            end
            DRAIN: if (bus.resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            mask_q          <= '0;
            we_q            <= 1'b0;
            rd_q            <= '0;
            rdw_q           <= 1'b0;
            size_q          <= 2'd0;
            zext_q          <= 1'b0;
            off_q           <= '0;
            result_q        <= '0;
            hold_q          <= 1'b0;
            hold_rdata_q    <= '0;
            hold_err_q      <= 1'b0;
            valid_out       <= 1'b0;
            rd_out          <= '0;
            rd_write_out    <= 1'b0;
            rd_value_out    <= '0;
            fault_out       <= 1'b0;
            fault_cause_out <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= {result_in[XLEN-1:OFFW], {OFFW{1'b0}}};
                wdata_q  <= write_in ? wdata_in : '0;
                mask_q   <= write_in ? mask_in : '0;
                we_q     <= write_in;
                rd_q     <= rd_in;
                rdw_q    <= rd_write_in;
                size_q   <= size_in;
                zext_q   <= width_in[2];
                off_q    <= off_in;
                result_q <= result_in;
            end
            if (cap_hold) begin
                hold_q       <= 1'b1;
                hold_rdata_q <= bus.rdata;
                hold_err_q   <= bus.err;
            end else if (clr_hold) begin
                hold_q <= 1'b0;
            end
            if (out_en) begin
                valid_out       <= o_valid;
                rd_out          <= o_rd;
                rd_write_out    <= o_rdw;
                rd_value_out    <= o_value;
                fault_out       <= o_fault;
                fault_cause_out <= o_cause;
            end
        end
    end

    assign busy_out      = (state_q != IDLE);
    assign bus.req_valid = (state_q == REQ);
    assign bus.we        = we_q;
    assign bus.addr      = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.wmask     = mask_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: inputs change on the falling edge, outputs checked on the falling edge.
module tb_mem_lsu;
    localparam int XLEN    = 64;
    localparam int RD_BITS = 5;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               stall_in, flush_in, valid_in, read_in, write_in, rd_write_in;
    logic [2:0]         width_in;
    logic [RD_BITS-1:0] rd_in;
    logic [XLEN-1:0]    result_in, rs2_value_in;
    logic               busy_out, valid_out, rd_write_out, fault_out;
    logic [RD_BITS-1:0] rd_out;
    logic [XLEN-1:0]    rd_value_out;
    logic [1:0]         fault_cause_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_lsu_if #(.XLEN(XLEN)) bus ();

    mem_lsu #(.XLEN(XLEN), .RD_BITS(RD_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush_in(flush_in),
        .valid_in(valid_in), .read_in(read_in), .write_in(write_in), .width_in(width_in),
        .rd_in(rd_in), .rd_write_in(rd_write_in), .result_in(result_in),
        .rs2_value_in(rs2_value_in), .busy_out(busy_out), .bus(bus.master),
        .valid_out(valid_out), .rd_out(rd_out), .rd_write_out(rd_write_out),
        .rd_value_out(rd_value_out), .fault_out(fault_out), .fault_cause_out(fault_cause_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_in();
        stall_in = 0; flush_in = 0; valid_in = 0; read_in = 0; write_in = 0;
        width_in = 3'd0; rd_in = '0; rd_write_in = 0; result_in = '0; rs2_value_in = '0;
        bus.req_ready = 0; bus.resp_valid = 0; bus.rdata = '0; bus.err = 0;
    endtask

    task automatic issue(input logic wr, input logic [2:0] w, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] d, input logic [RD_BITS-1:0] r);
        valid_in = 1; read_in = !wr; write_in = wr; width_in = w; result_in = a;
        rs2_value_in = d; rd_in = r; rd_write_in = !wr;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset busy got %0b exp 0", busy_out); end
        n_checks++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL reset req_valid got %0b exp 0", bus.req_valid); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset valid_out got %0b exp 0", valid_out); end
        n_checks++; if ({rd_write_out, fault_out, fault_cause_out} !== 4'b0) begin n_fail++; $display("FAIL reset flags got %b exp 0000", {rd_write_out, fault_out, fault_cause_out}); end
        n_checks++; if (rd_value_out !== '0) begin n_fail++; $display("FAIL reset rd_value got %h exp 0", rd_value_out); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_passthru();
        valid_in = 1; rd_in = 5'd5; rd_write_in = 1; result_in = 64'hABCD;
        tick();
        clear_in();
        n_checks++; if ({valid_out, rd_write_out} !== 2'b11) begin n_fail++; $display("FAIL pass valid/rdw got %b exp 11", {valid_out, rd_write_out}); end
        n_checks++; if (rd_out !== 5'd5) begin n_fail++; $display("FAIL pass rd got %0d exp 5", rd_out); end
        n_checks++; if (rd_value_out !== 64'hABCD) begin n_fail++; $display("FAIL pass value got %h exp abcd", rd_value_out); end
        n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL pass busy got %0b exp 0", busy_out); end
        tick();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL pass idle valid got %0b exp 0", valid_out); end
    endtask

    task automatic test_load_b();
        issue(0, 3'b000, 64'h1003, '0, 5'd7);
        tick();
        clear_in();
        n_checks++; if ({busy_out, bus.req_valid, valid_out} !== 3'b110) begin n_fail++; $display("FAIL ldb req busy/req/valid got %b exp 110", {busy_out, bus.req_valid, valid_out}); end
        n_checks++; if (bus.addr !== 64'h1000) begin n_fail++; $display("FAIL ldb addr got %h exp 1000", bus.addr); end
        n_checks++; if ({bus.we, bus.wmask} !== 9'h0) begin n_fail++; $display("FAIL ldb we/mask got %h exp 0", {bus.we, bus.wmask}); end
        bus.req_ready = 1;
        tick();
        bus.req_ready = 0;
        n_checks++; if ({bus.req_valid, valid_out} !== 2'b00) begin n_fail++; $display("FAIL ldb wait req/valid got %b exp 00", {bus.req_valid, valid_out}); end
        bus.resp_valid = 1; bus.rdata = 64'h0000_0000_8000_0000;
        tick();
        clear_in();
        n_checks++; if ({valid_out, rd_write_out, fault_out} !== 3'b110) begin n_fail++; $display("FAIL ldb retire valid/rdw/fault got %b exp 110", {valid_out, rd_write_out, fault_out}); end
        n_checks++; if (rd_value_out !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL ldb value got %h exp ffffffffffffff80", rd_value_out); end
        n_checks++; if ({rd_out, busy_out} !== {5'd7, 1'b0}) begin n_fail++; $display("FAIL ldb rd/busy got %b exp 001110", {rd_out, busy_out}); end
        tick();
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL ldb after valid got %0b exp 0", valid_out); end
    endtask

    task automatic test_store_h();
        issue(1, 3'b001, 64'h2006, 64'h1234, 5'd0);
        tick();
        clear_in();
        n_checks++; if (bus.wmask !== 8'hC0) begin n_fail++; $display("FAIL sth wmask got %h exp c0", bus.wmask); end
        n_checks++; if (bus.wdata !== 64'h1234_1234_1234_1234) begin n_fail++; $display("FAIL sth wdata got %h exp 1234123412341234", bus.wdata); end
        n_checks++; if ({bus.addr, bus.we, bus.req_valid} !== {64'h2000, 2'b11}) begin n_fail++; $display("FAIL sth addr/we/req got %h/%b%b exp 2000/11", bus.addr, bus.we, bus.req_valid); end
        bus.req_ready = 1;
        tick();
        bus.req_ready = 0; bus.resp_valid = 1;
        tick();
        clear_in();
        n_checks++; if ({valid_out, rd_write_out, fault_out} !== 3'b100) begin n_fail++; $display("FAIL sth retire got %b exp 100", {valid_out, rd_write_out, fault_out}); end
    endtask

    task automatic test_ready_hold();
        issue(0, 3'b110, 64'h4004, '0, 5'd9);
        tick();
        clear_in();
        for (int c = 0; c < 4; c++) begin
            n_checks++; if ({busy_out, bus.req_valid} !== 2'b11) begin n_fail++; $display("FAIL hold cyc%0d busy/req got %b exp 11", c, {busy_out, bus.req_valid}); end
            n_checks++; if (bus.addr !== 64'h4000) begin n_fail++; $display("FAIL hold cyc%0d addr got %h exp 4000", c, bus.addr); end
            bus.req_ready = (c == 3);
            tick();
        end
        bus.req_ready = 0;
        n_checks++; if ({busy_out, bus.req_valid} !== 2'b10) begin n_fail++; $display("FAIL hold wait busy/req got %b exp 10", {busy_out, bus.req_valid}); end
        bus.resp_valid = 1; bus.rdata = 64'h8765_4321_0000_0000;
        tick();
        clear_in();
        n_checks++; if ({valid_out, rd_value_out} !== {1'b1, 64'h0000_0000_8765_4321}) begin n_fail++; $display("FAIL hold lwu got %b/%h exp 1/0000000087654321", valid_out, rd_value_out); end
    endtask

    task automatic test_flush_wait();
        issue(0, 3'b011, 64'h5000, '0, 5'd3);
        tick();
        clear_in();
        bus.req_ready = 1;
        tick();
        bus.req_ready = 0; flush_in = 1;
        tick();
        flush_in = 0;
        n_checks++; if ({busy_out, valid_out} !== 2'b10) begin n_fail++; $display("FAIL fw drain busy/valid got %b exp 10", {busy_out, valid_out}); end
        bus.resp_valid = 1; bus.rdata = 64'h1111_2222_3333_4444;
        tick();
        clear_in();
        n_checks++; if ({busy_out, valid_out} !== 2'b00) begin n_fail++; $display("FAIL fw discard busy/valid got %b exp 00", {busy_out, valid_out}); end
        issue(0, 3'b100, 64'h5001, '0, 5'd4);
        tick();
        clear_in();
        n_checks++; if (bus.req_valid !== 1'b1) begin n_fail++; $display("FAIL fw next req got %0b exp 1", bus.req_valid); end
        bus.req_ready = 1;
        tick();
        bus.req_ready = 0; bus.resp_valid = 1; bus.rdata = 64'h0000_0000_0000_FF00;
        tick();
        clear_in();
        n_checks++; if ({valid_out, rd_value_out} !== {1'b1, 64'hFF}) begin n_fail++; $display("FAIL fw lbu got %b/%h exp 1/ff", valid_out, rd_value_out); end
    endtask

    task automatic test_flush_req();
        issue(0, 3'b011, 64'h7000, '0, 5'd2);
        tick();
        clear_in();
        flush_in = 1;
        tick();
        flush_in = 0;
        n_checks++; if ({busy_out, bus.req_valid, valid_out} !== 3'b000) begin n_fail++; $display("FAIL fr busy/req/valid got %b exp 000", {busy_out, bus.req_valid, valid_out}); end
    endtask

    task automatic test_bus_err();
        issue(0, 3'b010, 64'h8000, '0, 5'd6);
        tick();
        clear_in();
        bus.req_ready = 1;
        tick();
        bus.req_ready = 0; bus.resp_valid = 1; bus.err = 1; bus.rdata = 64'h55;
        tick();
        clear_in();
        n_checks++; if ({valid_out, fault_out, rd_write_out} !== 3'b110) begin n_fail++; $display("FAIL err valid/fault/rdw got %b exp 110", {valid_out, fault_out, rd_write_out}); end
        n_checks++; if (fault_cause_out !== 2'd2) begin n_fail++; $display("FAIL err cause got %0d exp 2", fault_cause_out); end
    endtask

    task automatic test_stall_resp();
        issue(0, 3'b001, 64'h6002, '0, 5'd8);
        tick();
        clear_in();
        bus.req_ready = 1;
        tick();
        bus.req_ready = 0; stall_in = 1; bus.resp_valid = 1; bus.rdata = 64'h0000_0000_F00D_0000;
        tick();
        bus.resp_valid = 0; bus.rdata = '0;
        for (int c = 0; c < 2; c++) begin
            n_checks++; if ({busy_out, valid_out} !== 2'b10) begin n_fail++; $display("FAIL stall cyc%0d busy/valid got %b exp 10", c, {busy_out, valid_out}); end
            if (c == 1) stall_in = 0;
            tick();
        end
        n_checks++; if ({valid_out, rd_value_out} !== {1'b1, 64'hFFFF_FFFF_FFFF_F00D}) begin n_fail++; $display("FAIL stall lh got %b/%h exp 1/fffffffffffff00d", valid_out, rd_value_out); end
    endtask

    task automatic test_misalign();
        issue(0, 3'b011, 64'h3004, '0, 5'd1);
        tick();
        clear_in();
`ifdef LSU_MISALIGN_TRAP_EN
        n_checks++; if ({bus.req_valid, busy_out} !== 2'b00) begin n_fail++; $display("FAIL mis req/busy got %b exp 00", {bus.req_valid, busy_out}); end
        n_checks++; if ({valid_out, fault_out, rd_write_out, fault_cause_out} !== 5'b11001) begin n_fail++; $display("FAIL mis retire got %b exp 11001", {valid_out, fault_out, rd_write_out, fault_cause_out}); end
`else
        n_checks++; if ({bus.req_valid, bus.addr} !== {1'b1, 64'h3000}) begin n_fail++; $display("FAIL mis req/addr got %b/%h exp 1/3000", bus.req_valid, bus.addr); end
        bus.req_ready = 1;
        tick();
        bus.req_ready = 0; bus.resp_valid = 1; bus.rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        clear_in();
        n_checks++; if ({valid_out, fault_out, rd_value_out} !== {2'b10, 64'h0123_4567_89AB_CDEF}) begin n_fail++; $display("FAIL mis ld got %b/%h exp 10/0123456789abcdef", {valid_out, fault_out}, rd_value_out); end
`endif
    endtask

    initial begin
        clear_in();
        @(negedge clk);
        test_reset();
        test_passthru();
        test_load_b();
        test_store_h();
        test_ready_hold();
        test_flush_wait();
        test_flush_req();
        test_bus_err();
        test_stall_resp();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
